dsc_s2b_frame: RTL and testbench
================================

Name: dsc_s2b_frame

Overview:
Stochastic-to-binary decoder for the deterministic stochastic computing (DSC) datapath. It consumes the serial product bitstream produced by the SNG/AND multiplier stage. It counts the ones over one frame of 2^FRAME_LOG2 valid bits, or over a shorter frame ended early by a stop strobe from the generator. The binary result is presented on a valid/ready output handshake. It replaces the free-running output counter with a framed, flow-controlled converter that a downstream consumer or scoreboard can sample unambiguously.

Parameters:
WIDTH, 16, result precision; equals NUM_INPUTS*SNG_WIDTH of the feeding multiplier.
FRAME_LOG2, 16, full frame length is 2^FRAME_LOG2 valid bits; legal range 1..WIDTH.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-low; sampled on the clk rising edge.
start  input  1  begins a new frame; honoured only in IDLE, or in DONE on the output handshake cycle.
sn_in  input  1  stochastic bit.
sn_valid  input  1  qualifies sn_in; a bit is counted only when sn_valid=1 in RUN.
stop  input  1  early termination of the current frame, e.g. the generator's overflow/exhaust flag.
z  output  WIDTH+1  ones count of the completed frame.
nbits  output  WIDTH+1  valid bits consumed in the completed frame.
early  output  1  1 = frame ended by stop before reaching the full length.
z_valid  output  1  result valid.
z_ready  input  1  consumer accepts the result.
busy  output  1  1 while in RUN.
start_err  output  1  one-cycle pulse when start arrives in RUN, or in DONE without a handshake; that start is dropped.

Behaviour:
- Reset (rst=0 at a clk edge): state goes to IDLE. z=0, nbits=0, early=0, z_valid=0, busy=0, start_err=0. Internal ones/bit counters are cleared. Reset wins over every other input, and a frame in progress is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - sn_in, sn_valid and stop are ignored.
  - start=1: clear both counters, go to RUN (busy=1 next cycle).
- RUN: on each cycle with sn_valid=1:
  - ones_cnt += sn_in;
  - bit_cnt += 1.
- Full-frame termination:
  - Triggered when the bit counted this cycle brings bit_cnt to 2^FRAME_LOG2.
  - Next cycle: state DONE, z=ones_cnt (including this bit), nbits=2^FRAME_LOG2, early=0, z_valid=1, busy=0.
- Early termination:
  - stop=1 in RUN: a bit qualified by sn_valid in the same cycle is counted, then the block goes to DONE with early=1.
  - stop coincident with the full-frame bit: treated as full frame, early=0.
  - stop with zero bits consumed: z=0, nbits=0, early=1.
- Latency: z_valid rises exactly 1 cycle after the terminating cycle.
- Arithmetic:
  - Counters are WIDTH+1 bits, so an all-ones full frame gives z=2^FRAME_LOG2 with no wrap.
  - Neither counter can exceed 2^FRAME_LOG2.
- DONE:
  - z, nbits and early are held stable while z_valid=1; sn_valid and stop are ignored.
  - Handshake (z_valid & z_ready): z_valid drops next cycle. Next state is RUN with cleared counters if start=1 in that cycle, else IDLE.
  - z, nbits and early keep their last values after the handshake until the next frame completes.
- start_err:
  - Pulses for one cycle for a start in RUN, or in DONE without z_ready.
  - The current frame and the held result are unaffected.
- z_ready outside DONE is ignored.

Test Plan:
(All scenarios with WIDTH=4, FRAME_LOG2=4, i.e. 16-bit frame.)
1. Reset, start, then 16 consecutive valid ones with z_ready=1 -> z_valid 1 cycle after the 16th bit, z=16 (5'b10000), nbits=16, early=0; state IDLE the cycle after the handshake.
2. Pattern 1,0 repeated, sn_valid low every 3rd cycle, until 16 valid bits -> z=8, nbits=16, early=0; sn_in during the gaps not counted.
3. start, 5 valid bits 1,1,0,1,0 with stop on the 5th -> z=3, nbits=5, early=1; stop on the 16th valid bit instead -> early=0, z includes that bit.
4. Frame done with z_ready=0 for 10 cycles -> z, nbits, early stable; start mid-hold -> start_err one-cycle pulse, no restart. Then z_ready=1 with start=1 in the same cycle -> z_valid low next cycle, busy=1, and a new frame counts from 0.
5. rst=0 after 7 valid bits in RUN -> next cycle all outputs 0, state IDLE. Subsequent sn_valid/sn_in without start produce no z_valid.
6. stop in the first RUN cycle with sn_valid=0 -> z=0, nbits=0, early=1, z_valid one cycle later.

Source files
------------

// File: rtl/dsc_s2b_frame.sv
// dsc_s2b_frame
// Framed stochastic-to-binary decoder. It counts the ones in a serial product
// bitstream over a frame of 2^FRAME_LOG2 valid bits, or over a shorter frame
// that a stop strobe ends early. The frame result is offered on a valid/ready
// handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   start      begin a new frame (IDLE, or DONE on the handshake cycle)
//   sn_in      stochastic bit
//   sn_valid   qualifies sn_in during RUN
//   stop       early frame termination
//   z          ones count of the completed frame (WIDTH+1 bits)
//   nbits      valid bits consumed by the completed frame (WIDTH+1 bits)
//   early      frame was ended by stop before reaching full length
//   z_valid    result valid
//   z_ready    consumer accepts the result
//   busy       frame in progress
//   start_err  one-cycle pulse for a dropped start
module dsc_s2b_frame #(
  parameter int WIDTH      = 16,
  parameter int FRAME_LOG2 = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sn_in,
  input  logic             sn_valid,
  input  logic             stop,
  output logic [WIDTH:0]   z,
  output logic [WIDTH:0]   nbits,
  output logic             early,
  output logic             z_valid,
  input  logic             z_ready,
  output logic             busy,
  output logic             start_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH:0] FRAME_LEN = {{WIDTH{1'b0}}, 1'b1} << FRAME_LOG2;

  state_t         state;
  logic [WIDTH:0] ones_cnt;
  logic [WIDTH:0] bit_cnt;
  logic [WIDTH:0] ones_next;
  logic [WIDTH:0] bits_next;
  logic           hit_full;

  // Counts including the bit presented this cycle; the terminating cycle
  // latches these so the last bit is part of the result.
  always_comb begin
    ones_next = ones_cnt + {{WIDTH{1'b0}}, sn_valid & sn_in};
    bits_next = bit_cnt + {{WIDTH{1'b0}}, sn_valid};
    hit_full  = sn_valid && (bits_next == FRAME_LEN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ones_cnt  <= '0;
      bit_cnt   <= '0;
      z         <= '0;
      nbits     <= '0;
      early     <= 1'b0;
      z_valid   <= 1'b0;
      busy      <= 1'b0;
      start_err <= 1'b0;
    end else begin
      start_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            ones_cnt <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b1;
          end
        end

        RUN: begin
          if (start) begin
            start_err <= 1'b1;
          end
          ones_cnt <= ones_next;
          bit_cnt  <= bits_next;
          // A full frame takes precedence over a coincident stop.
          if (hit_full || stop) begin
            state   <= DONE;
            z       <= ones_next;
            nbits   <= bits_next;
            early   <= !hit_full;
            z_valid <= 1'b1;
            busy    <= 1'b0;
          end
        end

        DONE: begin
          if (z_ready) begin
            z_valid <= 1'b0;
            if (start) begin
              state    <= RUN;
              ones_cnt <= '0;
              bit_cnt  <= '0;
              busy     <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (start) begin
            start_err <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsc_s2b_frame.sv
// Testbench for dsc_s2b_frame with WIDTH=4, FRAME_LOG2=4 (16-bit frames).
// Each frame's stimulus is stored as a per-cycle trace; the expected result
// is derived by scanning that trace against the framing rules.
module tb_dsc_s2b_frame;

  localparam int W  = 4;
  localparam int FL = 4;
  localparam int FRAME = 1 << FL;
  localparam int MAXC = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic sn_in = 1'b0;
  logic sn_valid = 1'b0;
  logic stop = 1'b0;
  logic z_ready = 1'b0;
  logic [W:0] z;
  logic [W:0] nbits;
  logic early;
  logic z_valid;
  logic busy;
  logic start_err;

  dsc_s2b_frame #(.WIDTH(W), .FRAME_LOG2(FL)) dut (
    .clk(clk), .rst(rst), .start(start), .sn_in(sn_in), .sn_valid(sn_valid),
    .stop(stop), .z(z), .nbits(nbits), .early(early), .z_valid(z_valid),
    .z_ready(z_ready), .busy(busy), .start_err(start_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  bit st_in  [MAXC];
  bit st_val [MAXC];
  bit st_stop[MAXC];
  int n_stim;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scan the trace: the frame ends at the first cycle where the valid-bit
  // total reaches FRAME (full) or where stop is seen (early).
  task automatic model(output int term, output int ez, output int en, output int ee);
    int ones = 0;
    int bits = 0;
    term = -1; ez = 0; en = 0; ee = 0;
    for (int i = 0; i < n_stim; i++) begin
      if (st_val[i]) begin
        ones += int'(st_in[i]);
        bits += 1;
      end
      if (bits == FRAME || st_stop[i]) begin
        term = i; ez = ones; en = bits; ee = (bits == FRAME) ? 0 : 1;
        break;
      end
    end
  endtask

  // Runs one frame from the stored trace and leaves the DUT in DONE.
  task automatic run_frame(input string name, input bit do_start);
    int term, ez, en, ee;
    model(term, ez, en, ee);
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
      chk({name, " busy_on_start"}, 32'(busy), 32'd1);
    end
    chk({name, " trace_terminates"}, 32'(term >= 0), 32'd1);
    if (term >= 0) begin
      for (int i = 0; i <= term; i++) begin
        sn_in = st_in[i]; sn_valid = st_val[i]; stop = st_stop[i];
        step();
        if (i < term) begin
          chk({name, " z_valid_low_in_run"}, 32'(z_valid), 32'd0);
        end
      end
      sn_in = 1'b0; sn_valid = 1'b0; stop = 1'b0;
      chk({name, " z_valid"}, 32'(z_valid), 32'd1);
      chk({name, " z"}, 32'(z), 32'(ez));
      chk({name, " nbits"}, 32'(nbits), 32'(en));
      chk({name, " early"}, 32'(early), 32'(ee));
      chk({name, " busy_done"}, 32'(busy), 32'd0);
      $display("frame %s: z=%0d nbits=%0d early=%0d (model z=%0d nbits=%0d early=%0d)",
               name, z, nbits, early, ez, en, ee);
    end
  endtask

  task automatic handshake(input string name);
    z_ready = 1'b1;
    step();
    z_ready = 1'b0;
    chk({name, " z_valid_after_hs"}, 32'(z_valid), 32'd0);
    chk({name, " busy_after_hs"}, 32'(busy), 32'd0);
  endtask

  task automatic gen_random(input int len, input int pstop);
    n_stim = len;
    for (int i = 0; i < len; i++) begin
      st_val[i]  = ($urandom % 4) != 0;
      st_in[i]   = $urandom % 2;
      st_stop[i] = ($urandom % pstop) == 0;
    end
    st_stop[len-1] = 1'b1;
  endtask

  initial begin
    logic [W:0] hz, hn;
    logic       he;

    // Reset state
    rst = 1'b0;
    step(); step();
    chk("rst z", 32'(z), 32'd0);
    chk("rst nbits", 32'(nbits), 32'd0);
    chk("rst early", 32'(early), 32'd0);
    chk("rst z_valid", 32'(z_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst start_err", 32'(start_err), 32'd0);
    rst = 1'b1;
    step();

    // 1: 16 consecutive ones, consumer always ready
    n_stim = FRAME;
    for (int i = 0; i < FRAME; i++) begin
      st_in[i] = 1'b1; st_val[i] = 1'b1; st_stop[i] = 1'b0;
    end
    z_ready = 1'b1;
    run_frame("t1_all_ones", 1'b1);
    chk("t1 z_is_16", 32'(z), 32'd16);
    step();
    chk("t1 z_valid_after_hs", 32'(z_valid), 32'd0);
    chk("t1 idle_busy", 32'(busy), 32'd0);
    chk("t1 z_held_after_hs", 32'(z), 32'd16);
    z_ready = 1'b0;

    // 2: 1,0 pattern with a gap every third cycle; gap bits are driven as 1
    begin
      int nv = 0;
      n_stim = 24;
      for (int i = 0; i < 24; i++) begin
        st_val[i] = (i % 3) != 2;
        st_stop[i] = 1'b0;
        if (st_val[i]) begin
          st_in[i] = (nv % 2) == 0;
          nv++;
        end else begin
          st_in[i] = 1'b1;
        end
      end
    end
    run_frame("t2_gapped", 1'b1);
    chk("t2 z_is_8", 32'(z), 32'd8);
    handshake("t2");

    // 3a: five bits 1,1,0,1,0 with stop on the fifth
    n_stim = 5;
    st_in[0] = 1; st_in[1] = 1; st_in[2] = 0; st_in[3] = 1; st_in[4] = 0;
    for (int i = 0; i < 5; i++) begin
      st_val[i] = 1'b1; st_stop[i] = (i == 4);
    end
    run_frame("t3_stop5", 1'b1);
    chk("t3 z_is_3", 32'(z), 32'd3);
    chk("t3 early_is_1", 32'(early), 32'd1);
    handshake("t3a");

    // 3b: stop coincident with the 16th valid bit is a full frame
    n_stim = FRAME;
    for (int i = 0; i < FRAME; i++) begin
      st_in[i] = $urandom % 2; st_val[i] = 1'b1; st_stop[i] = (i == FRAME - 1);
    end
    st_in[FRAME-1] = 1'b1;
    run_frame("t3_stop16", 1'b1);
    chk("t3b early_is_0", 32'(early), 32'd0);
    handshake("t3b");

    // 4: held result under backpressure, dropped start, handshake+restart
    gen_random(40, 25);
    run_frame("t4_hold", 1'b1);
    hz = z; hn = nbits; he = early;
    for (int c = 0; c < 10; c++) begin
      start = (c == 5);
      step();
      start = 1'b0;
      chk("t4 hold_z", 32'(z), 32'(hz));
      chk("t4 hold_nbits", 32'(nbits), 32'(hn));
      chk("t4 hold_early", 32'(early), 32'(he));
      chk("t4 hold_z_valid", 32'(z_valid), 32'd1);
      chk("t4 hold_start_err", 32'(start_err), 32'(c == 5));
      chk("t4 hold_busy", 32'(busy), 32'd0);
    end
    z_ready = 1'b1; start = 1'b1;
    step();
    z_ready = 1'b0; start = 1'b0;
    chk("t4 restart_z_valid", 32'(z_valid), 32'd0);
    chk("t4 restart_busy", 32'(busy), 32'd1);
    gen_random(40, 40);
    run_frame("t4_after_restart", 1'b0);
    handshake("t4b");

    // start during RUN is dropped and the frame continues
    start = 1'b1;
    step();
    chk("run_start busy", 32'(busy), 32'd1);
    step();
    start = 1'b0;
    chk("run_start start_err", 32'(start_err), 32'd1);
    chk("run_start busy_kept", 32'(busy), 32'd1);
    gen_random(30, 30);
    run_frame("t_runstart", 1'b0);
    handshake("t_runstart");

    // 5: reset mid-frame after 7 valid bits
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sn_in = 1'b1; sn_valid = 1'b1;
      step();
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t5 z", 32'(z), 32'd0);
    chk("t5 nbits", 32'(nbits), 32'd0);
    chk("t5 early", 32'(early), 32'd0);
    chk("t5 z_valid", 32'(z_valid), 32'd0);
    chk("t5 busy", 32'(busy), 32'd0);
    for (int i = 0; i < 20; i++) begin
      sn_in = $urandom % 2; sn_valid = 1'b1; stop = (i == 10);
      step();
      chk("t5 idle_no_z_valid", 32'(z_valid), 32'd0);
    end
    sn_valid = 1'b0; stop = 1'b0;

    // 6: stop in the first RUN cycle with no valid bit
    n_stim = 1;
    st_in[0] = 1'b1; st_val[0] = 1'b0; st_stop[0] = 1'b1;
    run_frame("t6_empty", 1'b1);
    chk("t6 nbits_is_0", 32'(nbits), 32'd0);
    handshake("t6");

    // Randomised frames
    for (int f = 0; f < 8; f++) begin
      gen_random(MAXC, (f % 2) ? 12 : 60);
      run_frame($sformatf("rand%0d", f), 1'b1);
      handshake($sformatf("rand%0d", f));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
